truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
// PURPOSE
//  Sequential sweeper/checker for a 4-input combinational function block (fxy family).
//  - Upstream role: drives all 16 input vectors {x,y,w,z} into the function block.
//  - Downstream role: samples the function output s for each vector.
//  - Packs the samples into a 16-bit truth-table word and compares it with an expected
//    minterm mask.
//  - Replaces hand-written exhaustive testbench stimulus with a reusable on-chip checker.
// PARAMETERS
//  SETTLE_CYCLES  1  extra dwell cycles per vector before s is sampled; legal range 0..7
// PORTS
//  clk             in   1   single clock, rising edge
//  reset           in   1   synchronous, active-high reset
//  start           in   1   scan request; sampled only in IDLE
//  expected        in   16  expected truth table; bit i = f(i); latched when start accepted
//  x               out  1   vector bit 3 (MSB) to function block
//  y               out  1   vector bit 2
//  w               out  1   vector bit 1
//  z               out  1   vector bit 0 (LSB)
//  s               in   1   function block output, combinational from x,y,w,z
//  busy            out  1   scan in progress
//  done            out  1   one-cycle pulse: scan complete, results valid
//  pass            out  1   1 when truth_table == expected
//  truth_table     out  16  captured table; bit i = s sampled for index i = {x,y,w,z}
//  mismatch_count  out  5   number of differing bits, 0..16
//  fail_index      out  4   lowest mismatching index; 0 when pass=1
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - state=IDLE; all outputs 0, including x,y,w,z, pass, truth_table, mismatch_count
//      and fail_index.
//    - Vector counter, dwell counter and latched expected are cleared.
//  - Reset has priority over every other input, including mid-scan:
//    - The scan aborts immediately.
//    - done is not pulsed.
//    - Results are cleared to 0.
//  - States:
//    - IDLE: x,y,w,z=0; busy=0.
//      - start=1 at edge E0 -> SCAN. At E0: latch expected, vector=0, dwell=0.
//    - SCAN: busy=1; {x,y,w,z}=vector (registered outputs).
//      - Each vector is held exactly SETTLE_CYCLES+1 cycles.
//      - At the last edge of the vector: truth_table[vector] <= s.
//      - Then, if vector<15: vector+1, dwell=0.
//      - Otherwise -> DONE.
//      - start is ignored while in SCAN.
//    - DONE: one cycle. done=1, busy=0, pass/mismatch_count/fail_index valid; x,y,w,z=0.
//      - Unconditionally -> IDLE.
//      - start is ignored in this cycle.
//  - Latency: done rises 16*(SETTLE_CYCLES+1) edges after E0 (32 edges for the default).
//  - Result registers:
//    - Updated at the same edge done rises.
//    - Held until the next accepted start, which clears them to 0 at E0.
//    - Held until reset.
//  - Result computation:
//    - diff = truth_table ^ expected_latched.
//    - mismatch_count = popcount(diff), a 5-bit unsigned count, so 16 is representable.
//    - pass = (diff==0).
//    - fail_index = index of the lowest set bit of diff, or 0 when diff==0.
//  - The expected port may change during SCAN without effect; only the latched copy is
//    used.
//  - s is sampled only at vector-final edges; s glitches at vector transitions are
//    ignored.
//  - Vector counter wrap: counts 0..15 only and never wraps within a scan.
// TESTING
//  1. Reset asserted 2 cycles, start=0
//     -> busy=0, done=0, pass=0, truth_table=16'h0000, x=y=w=z=0.
//  2. Connect fxy (minterms 1,2,5,8,10,12,13); expected=16'h3526; start pulsed
//     -> done at edge 32 after E0, truth_table=16'h3526, pass=1, mismatch_count=0,
//        fail_index=0.
//  3. Same DUT; expected=16'h3527
//     -> pass=0, mismatch_count=1, fail_index=0.
//     Then expected=16'h0000 -> mismatch_count=7, fail_index=1.
//  4. start held high through the whole scan
//     -> exactly one scan, one done pulse, new scan accepted only from IDLE.
//     Changing expected mid-scan does not change the result.
//  5. Reset asserted while vector=5
//     -> next cycle busy=0, x,y,w,z=0, truth_table=0; done never pulses for the
//        aborted scan.
//  6. SETTLE_CYCLES=0 with fxy, expected=16'h3526
//     -> done at edge 16 after E0, pass=1; each vector is visible on x,y,w,z for
//        exactly 1 cycle.

Source files
------------

// File: rtl/truth_table_scanner_if.sv
// Bundle between the truth-table scanner, its requester and the
// function block under test.
interface truth_table_scanner_if;
    logic        start;
    logic [15:0] expected;
    logic        x;
    logic        y;
    logic        w;
    logic        z;
    logic        s;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] truth_table;
    logic [4:0]  mismatch_count;
    logic [3:0]  fail_index;

    modport master (
        output start,
        output expected,
        output s,
        input  x,
        input  y,
        input  w,
        input  z,
        input  busy,
        input  done,
        input  pass,
        input  truth_table,
        input  mismatch_count,
        input  fail_index
    );

    modport slave (
        input  start,
        input  expected,
        input  s,
        output x,
        output y,
        output w,
        output z,
        output busy,
        output done,
        output pass,
        output truth_table,
        output mismatch_count,
        output fail_index
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps all 16 {x,y,w,z} vectors through a 4-input function block,
// captures its truth table and compares it with a latched mask.
module truth_table_scanner #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic                   clk,
    input logic                   reset,
    truth_table_scanner_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    localparam logic [2:0] DWELL_LAST = 3'(SETTLE_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [2:0]  dwell_q, dwell_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] tt_q, tt_d;
    logic        pass_q, pass_d;
    logic [4:0]  mm_q, mm_d;
    logic [3:0]  fi_q, fi_d;

    logic [15:0] tt_fin;
    logic [15:0] diff;
    logic [4:0]  pop;
    logic [3:0]  low;

    // Table including the sample taken at this edge, so the
    // final vector's bit is in the result computed at DONE entry.
    always_comb begin
        tt_fin        = tt_q;
        tt_fin[vec_q] = bus.s;
        diff          = tt_fin ^ exp_q;
        pop           = '0;
        low           = '0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) begin
                pop = pop + 5'd1;
                low = 4'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        dwell_d = dwell_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        pass_d  = pass_q;
        mm_d    = mm_q;
        fi_d    = fi_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    exp_d   = bus.expected;
                    vec_d   = '0;
                    dwell_d = '0;
                    tt_d    = '0;
                    pass_d  = 1'b0;
                    mm_d    = '0;
                    fi_d    = '0;
                end
            end
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    tt_d = tt_fin;
                    if (vec_q == 4'd15) begin
                        state_d = DONE;
                        pass_d  = (diff == '0);
                        mm_d    = pop;
                        fi_d    = low;
                    end else begin
                        vec_d   = vec_q + 4'd1;
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            dwell_q <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            pass_q  <= 1'b0;
            mm_q    <= '0;
            fi_q    <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
            mm_q    <= mm_d;
            fi_q    <= fi_d;
        end
    end

    assign {bus.x, bus.y, bus.w, bus.z} =
        (state_q == SCAN) ? vec_q : 4'b0000;
    assign bus.busy           = (state_q == SCAN);
    assign bus.done           = (state_q == DONE);
    assign bus.pass           = pass_q;
    assign bus.truth_table    = tt_q;
    assign bus.mismatch_count = mm_q;
    assign bus.fail_index     = fi_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: a slow (dwell 2) and a fast
// (dwell 1) instance driven against a behavioural function block.
module tb_truth_table_scanner;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    truth_table_scanner_if if0 ();
    truth_table_scanner_if if1 ();

    logic [15:0] fmask;
    assign if0.s = fmask[{if0.x, if0.y, if0.w, if0.z}];
    assign if1.s = fmask[{if1.x, if1.y, if1.w, if1.z}];

    truth_table_scanner #(.SETTLE_CYCLES(1)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    truth_table_scanner #(.SETTLE_CYCLES(0)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    typedef struct packed {
        logic [15:0] tt;
        logic        ps;
        logic [4:0]  mm;
        logic [3:0]  fi;
    } res_t;

    typedef struct {
        logic [15:0] f;
        logic [15:0] ex;
        res_t        want;
    } vec_t;

    res_t sb_q[$];
    vec_t tbl[6];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int act,
                       input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h",
                      nm, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic st,
                         input logic [15:0] ex);
        if (sel) begin
            if1.start    = st;
            if1.expected = ex;
        end else begin
            if0.start    = st;
            if0.expected = ex;
        end
    endtask

    function automatic logic g_busy(input bit sel);
        return sel ? if1.busy : if0.busy;
    endfunction

    function automatic logic g_done(input bit sel);
        return sel ? if1.done : if0.done;
    endfunction

    function automatic logic [3:0] g_vec(input bit sel);
        return sel ? {if1.x, if1.y, if1.w, if1.z}
                   : {if0.x, if0.y, if0.w, if0.z};
    endfunction

    function automatic logic [15:0] g_tt(input bit sel);
        return sel ? if1.truth_table : if0.truth_table;
    endfunction

    function automatic res_t g_res(input bit sel);
        res_t r;
        if (sel) r = {if1.truth_table, if1.pass,
                      if1.mismatch_count, if1.fail_index};
        else     r = {if0.truth_table, if0.pass,
                      if0.mismatch_count, if0.fail_index};
        return r;
    endfunction

    task automatic scan(input bit sel, input logic [15:0] ex,
                        input res_t want, input int lat,
                        input bit hold);
        int         n;
        bit         seen;
        int         run;
        int         errs;
        int         dw;
        logic [3:0] cur;
        res_t       got;
        res_t       exp_r;
        dw = lat / 16;
        drive(sel, 1'b1, ex);
        sb_q.push_back(want);
        tick();
        chk("busy_at_e0", int'(g_busy(sel)), 1);
        chk("clear_at_e0", int'(g_tt(sel)), 0);
        if (!hold) drive(sel, 1'b0, ex);
        cur  = g_vec(sel);
        run  = 1;
        errs = (cur != 4'd0) ? 1 : 0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < lat + 8) begin
            tick();
            n++;
            if (hold && n == 10) drive(sel, 1'b1, ~ex);
            if (g_done(sel)) begin
                seen = 1'b1;
            end else if (g_busy(sel)) begin
                if (g_vec(sel) == cur) begin
                    run++;
                end else begin
                    if (run != dw || g_vec(sel) != cur + 4'd1)
                        errs++;
                    cur = g_vec(sel);
                    run = 1;
                end
            end
        end
        if (run != dw || cur != 4'd15) errs++;
        chk("done_seen", int'(seen), 1);
        chk("latency", n, lat);
        chk("dwell", errs, 0);
        if (seen) begin
            exp_r = sb_q.pop_front();
            got   = g_res(sel);
            chk("tt", int'(got.tt), int'(exp_r.tt));
            chk("pass", int'(got.ps), int'(exp_r.ps));
            chk("mm", int'(got.mm), int'(exp_r.mm));
            chk("fi", int'(got.fi), int'(exp_r.fi));
            chk("busy_in_done", int'(g_busy(sel)), 0);
            chk("vec_in_done", int'(g_vec(sel)), 0);
        end else begin
            sb_q.delete();
        end
        tick();
        chk("done_one_cycle", int'(g_done(sel)), 0);
        chk("idle_after_done", int'(g_busy(sel)), 0);
    endtask

    initial begin
        int   k;
        int   dn;
        res_t r;

        tbl[0] = '{16'h3526, 16'h3526, '{16'h3526, 1'b1, 5'd0,  4'd0}};
        tbl[1] = '{16'h3526, 16'h3527, '{16'h3526, 1'b0, 5'd1,  4'd0}};
        tbl[2] = '{16'h3526, 16'h0000, '{16'h3526, 1'b0, 5'd7,  4'd1}};
        tbl[3] = '{16'hFFFF, 16'h0000, '{16'hFFFF, 1'b0, 5'd16, 4'd0}};
        tbl[4] = '{16'h0000, 16'h8000, '{16'h0000, 1'b0, 5'd1,  4'd15}};
        tbl[5] = '{16'hA5A5, 16'h5AA5, '{16'hA5A5, 1'b0, 5'd8,  4'd8}};

        fmask = 16'h3526;
        drive(1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 16'h0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", int'(if0.busy), 0);
        chk("rst_done", int'(if0.done), 0);
        chk("rst_pass", int'(if0.pass), 0);
        chk("rst_tt", int'(if0.truth_table), 0);
        chk("rst_vec", int'(g_vec(1'b0)), 0);
        chk("rst_mm", int'(if0.mismatch_count), 0);
        chk("rst_fi", int'(if0.fail_index), 0);

        for (int i = 0; i < 6; i++) begin
            fmask = tbl[i].f;
            scan(1'b0, tbl[i].ex, tbl[i].want, 32, 1'b0);
        end

        repeat (3) tick();
        r = g_res(1'b0);
        chk("hold_tt", int'(r.tt), 16'hA5A5);
        chk("hold_mm", int'(r.mm), 8);

        // start held through the scan, expected flipped mid-scan
        fmask = 16'h3526;
        scan(1'b0, 16'h3526, '{16'h3526, 1'b1, 5'd0, 4'd0},
             32, 1'b1);
        tick();
        chk("restart_from_idle", int'(if0.busy), 1);
        drive(1'b0, 1'b0, 16'h0);

        // abort mid-scan once vector 5 is on the outputs
        k = 0;
        while (g_vec(1'b0) != 4'd5 && k < 40) begin
            tick();
            k++;
        end
        chk("reach_vec5", int'(g_vec(1'b0)), 5);
        reset = 1'b1;
        tick();
        chk("abort_busy", int'(if0.busy), 0);
        chk("abort_vec", int'(g_vec(1'b0)), 0);
        chk("abort_tt", int'(if0.truth_table), 0);
        chk("abort_done", int'(if0.done), 0);
        reset = 1'b0;
        dn = 0;
        repeat (40) begin
            tick();
            if (if0.done) dn++;
        end
        chk("no_done_after_abort", dn, 0);

        fmask = 16'h3526;
        scan(1'b1, 16'h3526, '{16'h3526, 1'b1, 5'd0, 4'd0},
             16, 1'b0);
        scan(1'b1, 16'h0000, '{16'h3526, 1'b0, 5'd7, 4'd1},
             16, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
